// File: rtl/mul_pkg.sv
// Shared types and width limits for the sequential shift-add / Booth multiplier.
package mul_pkg;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  function automatic bit width_ok(input int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/mul_booth_step.sv
// One multiply iteration: optional add/sub of M into A, then a right shift of {A,Q,Q-1}.
module mul_booth_step
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  input  logic             signed_mode,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  booth_op_e        op;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  // Signed mode uses the Booth pair {Q0,Q-1}; unsigned mode adds on Q0 alone.
  always_comb begin
    op = NOP;
    if (signed_mode) begin
      case ({q[0], q_m1})
        2'b10:   op = SUB;
        2'b01:   op = ADD;
        default: op = NOP;
      endcase
    end else if (q[0]) begin
      op = ADD;
    end
  end

  assign m_ext = signed_mode ? {m[WIDTH-1], m} : {1'b0, m};

  always_comb begin
    sum = a;
    case (op)
      ADD:     sum = a + m_ext;
      SUB:     sum = a - m_ext;
      default: sum = a;
    endcase
  end

  // In unsigned mode sum[WIDTH] is the carry, shifted into A with a zero fill.
  assign a_nxt    = {signed_mode & sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/transfer_and_nbit.sv
// N-bit bus gate: passes data when enabled, drives zero otherwise.
module transfer_and_nbit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  assign out = data & {WIDTH{en}};

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential WIDTH-cycle multiplier with start/busy/done handshake and gated S-bus outputs.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             CLK_50,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A_bus_in,
  input  logic [WIDTH-1:0] B_bus_in,
  input  logic             MUL1,
  input  logic             MUL2_1,
  input  logic             MUL2_2,
  input  logic             start,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  input  logic             ALS_H6_a,
  input  logic             ALS_H6_q,
  output logic [WIDTH-1:0] H6_a_out,
  output logic [WIDTH-1:0] H6_q_out,
  output logic [WIDTH-1:0] A_mul_bus,
  output logic [WIDTH-1:0] Q_mul_bus,
  output logic             alu_carryOut,
  output logic             alu_overflowOut
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("mul_seq_unit: WIDTH must be within 4..32");
  end

  state_e             state;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_src;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1;
  logic               mode;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     a_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               q_m1_nxt;
  logic               load_q;

  assign load_q = MUL2_1 | MUL2_2;

  mul_booth_step #(.WIDTH(WIDTH)) u_step (
    .a           (a_reg),
    .q           (q_reg),
    .q_m1        (q_m1),
    .m           (m_reg),
    .signed_mode (mode),
    .a_nxt       (a_nxt),
    .q_nxt       (q_nxt),
    .q_m1_nxt    (q_m1_nxt)
  );

  // Control, operand registers and product state; loads and start are only honoured outside CALC.
  always_ff @(posedge CLK_50 or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      m_reg           <= '0;
      q_src           <= '0;
      a_reg           <= '0;
      q_reg           <= '0;
      q_m1            <= 1'b0;
      mode            <= 1'b0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      alu_carryOut    <= 1'b0;
      alu_overflowOut <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_m1_nxt;
          if (cnt == '0) begin
            state           <= DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            alu_carryOut    <= mode ? 1'b0 : (|a_nxt[WIDTH-1:0]);
            alu_overflowOut <= mode ? (a_nxt[WIDTH-1:0] != {WIDTH{q_nxt[WIDTH-1]}})
                                    : (|a_nxt[WIDTH-1:0]);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          if (MUL1)   m_reg <= A_bus_in;
          if (load_q) q_src <= B_bus_in;
          if (start) begin
            a_reg           <= '0;
            q_reg           <= load_q ? B_bus_in : q_src;
            q_m1            <= 1'b0;
            mode            <= signed_mode & SIGNED_EN;
            cnt             <= CNT_W'(WIDTH - 1);
            state           <= CALC;
            busy            <= 1'b1;
            done            <= 1'b0;
            alu_carryOut    <= 1'b0;
            alu_overflowOut <= 1'b0;
          end else if (MUL1 || load_q) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign A_mul_bus = a_reg[WIDTH-1:0];
  assign Q_mul_bus = q_reg;

  transfer_and_nbit #(.WIDTH(WIDTH)) u_gate_a (
    .data (a_reg[WIDTH-1:0]),
    .en   (ALS_H6_a),
    .out  (H6_a_out)
  );

  transfer_and_nbit #(.WIDTH(WIDTH)) u_gate_q (
    .data (q_reg),
    .en   (ALS_H6_q),
    .out  (H6_q_out)
  );

endmodule
